// File: rtl/reg_spi_bridge.sv
// SPI-slave (mode 0) to register-bus bridge: decodes 32-bit host frames into
// single-cycle wr_en/rd_en strobes and shifts read data back out on MISO.
module reg_spi_bridge #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_WDATA, S_RD_LOAD, S_RDATA, S_SKIP, S_DONE
  } state_t;

  localparam logic [5:0] HDR_LAST   = 6'd15;
  localparam logic [5:0] FRAME_LAST = 6'd31;
  localparam logic [5:0] FIRST_OUT  = 6'd17;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
  logic                    sclk_dly_q, sclk_dly_d;
  logic                    cs_dly_q, cs_dly_d;
  logic                    armed_q, armed_d;
  logic [5:0]              cnt_q, cnt_d;
  logic [DATA_W-1:0]       shift_q, shift_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    wr_en_q, wr_en_d;
  logic                    rd_en_q, rd_en_d;
  logic                    miso_q, miso_d;
  logic                    oe_q, oe_d;

  logic              sclk_s, cs_s, mosi_s;
  logic              sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [DATA_W-1:0] shift_in;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  // Chains reset to 0, so a CS fall is only seen after CS was observed high.
  assign cs_rise   = cs_s & ~cs_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;
  assign shift_in  = {shift_q[DATA_W-2:0], mosi_s};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_dly_d  = sclk_s;
    cs_dly_d    = cs_s;
    armed_d     = armed_q | cs_s;
    oe_d        = armed_q & ~cs_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    miso_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          cnt_d   = 6'd0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (cs_rise) begin
          state_d = S_IDLE;
        end else if (sclk_rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == HDR_LAST) begin
            if (shift_in[DATA_W-2]) begin
              state_d = S_SKIP;
            end else begin
              addr_d = shift_in[ADDR_W-1:0];
              if (shift_in[DATA_W-1]) begin
                state_d = S_WDATA;
              end else begin
                rd_en_d = 1'b1;
                state_d = S_RD_LOAD;
              end
            end
          end
        end
      end
      S_WDATA: begin
        if (cs_rise) begin
          state_d = S_IDLE;
        end else if (sclk_rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == FRAME_LAST) begin
            wdata_d = shift_in;
            wr_en_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RD_LOAD: begin
        if (cs_rise) begin
          state_d = S_IDLE;
        end else begin
          shift_d = {read_data[DATA_W-2:0], 1'b0};
          miso_d  = read_data[DATA_W-1];
          state_d = S_RDATA;
        end
      end
      S_RDATA: begin
        if (cs_rise) begin
          state_d = S_IDLE;
        end else begin
          miso_d = miso_q;
          if (sclk_rise) begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == FRAME_LAST) begin
              miso_d  = 1'b0;
              state_d = S_DONE;
            end
          end else if (sclk_fall && cnt_q >= FIRST_OUT) begin
            // The fall between rises 16 and 17 must not shift: bit 15 is already out.
            miso_d  = shift_q[DATA_W-1];
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      S_SKIP, S_DONE: begin
        if (cs_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b0;
      armed_q     <= 1'b0;
      cnt_q       <= 6'd0;
      shift_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      cs_dly_q    <= cs_dly_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign addr        = addr_q;
  assign write_data  = wdata_q;

endmodule

// File: tb/tb_reg_spi_bridge.sv
// Bench for reg_spi_bridge: drives SPI mode-0 frames at clk = 8x sclk and checks
// strobes and MISO against a frame-level register-file model.
module tb_reg_spi_bridge;
  localparam int HALF = 40;  // sclk half period = 4 clk cycles
  localparam int GAP  = 40;  // minimum CS-high gap (SYNC_STAGES+2 cycles)

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe, wr_en, rd_en;
  logic [13:0] addr;
  logic [15:0] write_data;
  logic [15:0] read_data;

  bit [15:0]   regs[16384];
  bit [15:0]   ref_regs[16384];
  logic [29:0] wr_log[$];
  logic [13:0] rd_log[$];
  int          overlap = 0;
  int          tests_run = 0;
  int          tests_failed = 0;

  reg_spi_bridge dut (
    .clk(clk), .rst(rst),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  // Register file emulation: combinational read, write on strobe.
  assign read_data = regs[addr];
  always @(posedge clk) if (wr_en) regs[addr] <= write_data;

  always @(negedge clk) begin
    if (wr_en) wr_log.push_back({addr, write_data});
    if (rd_en) rd_log.push_back(addr);
    if (wr_en && rd_en) overlap++;
  end

  // Host side of one SPI bit: MOSI changes on fall, MISO sampled at the rise.
  task automatic spi_bit(input logic b, output logic m, output logic oe);
    spi_mosi = b;
    #HALF;
    spi_sclk = 1'b1;
    m  = spi_miso;
    oe = spi_miso_oe;
    #HALF;
    spi_sclk = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] w, input int nbits, output logic [31:0] m,
                           output logic oe_and, output logic oe_or);
    logic b, oe;
    m = '0; oe_and = 1'b1; oe_or = 1'b0;
    spi_cs_n = 1'b0;
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      spi_bit((i < 32) ? w[31-i] : 1'b1, b, oe);
      if (i < 32) m[31-i] = b;
      oe_and &= oe;
      oe_or  |= oe;
    end
    #HALF;
    spi_cs_n = 1'b1;
    #GAP;
  endtask

  // Frame-level reference: what the register bus and MISO should show.
  task automatic model_frame(input logic [31:0] w, input int nbits,
                             output int n_wr, output logic [29:0] wr_item,
                             output int n_rd, output logic [13:0] rd_item,
                             output logic [31:0] miso);
    n_wr = 0; n_rd = 0; wr_item = '0; rd_item = '0; miso = '0;
    if (nbits < 16 || w[30]) return;
    if (w[31]) begin
      if (nbits >= 32) begin
        n_wr = 1;
        wr_item = w[29:0];
        ref_regs[w[29:16]] = w[15:0];
      end
    end else begin
      n_rd = 1;
      rd_item = w[29:16];
      miso = {16'h0000, ref_regs[w[29:16]]};
      if (nbits < 32) miso &= ~((32'h1 << (32 - nbits)) - 32'h1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({wr_en, rd_en, spi_miso, spi_miso_oe} !== 4'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: wr/rd/miso/oe=%b required 0000", {wr_en, rd_en, spi_miso, spi_miso_oe});
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({addr, write_data} !== 30'h0 || spi_miso_oe !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_data: addr=%h wdata=%h oe=%b required 0 0 0", addr, write_data, spi_miso_oe);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    int n_wr, n_rd; logic [29:0] ew; logic [13:0] er; logic [31:0] em, m; logic oa, oo;
    wr_log.delete(); rd_log.delete();
    model_frame(32'h8401BEEF, 32, n_wr, ew, n_rd, er, em);
    run_frame(32'h8401BEEF, 32, m, oa, oo);
    tests_run++;
    if (wr_log.size() != 1 || wr_log[0] !== ew || rd_log.size() != 0) begin
      tests_failed++;
      $display("FAIL write_401: wr=%0d rd=%0d first=%h required 1 0 %h", wr_log.size(), rd_log.size(),
               (wr_log.size() > 0) ? wr_log[0] : 30'h0, ew);
    end
    tests_run++;
    if (m !== em || oa !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_miso_oe: miso=%h oe_all=%b required %h 1", m, oa, em);
    end
  endtask

  task automatic test_read();
    int n_wr, n_rd; logic [29:0] ew; logic [13:0] er; logic [31:0] em, m; logic oa, oo;
    model_frame(32'h84021234, 32, n_wr, ew, n_rd, er, em);
    run_frame(32'h84021234, 32, m, oa, oo);
    wr_log.delete(); rd_log.delete();
    model_frame(32'h04020000, 32, n_wr, ew, n_rd, er, em);
    run_frame(32'h04020000, 32, m, oa, oo);
    tests_run++;
    if (rd_log.size() != 1 || rd_log[0] !== 14'h402 || wr_log.size() != 0) begin
      tests_failed++;
      $display("FAIL read_402_strobe: rd=%0d wr=%0d addr=%h required 1 0 402", rd_log.size(), wr_log.size(),
               (rd_log.size() > 0) ? rd_log[0] : 14'h0);
    end
    tests_run++;
    if (m !== 32'h00001234 || m !== em) begin
      tests_failed++;
      $display("FAIL read_402_miso: got %h required %h", m, em);
    end
  endtask

  task automatic test_abort();
    int n_wr, n_rd; logic [29:0] ew; logic [13:0] er; logic [31:0] em, m; logic oa, oo;
    wr_log.delete(); rd_log.delete();
    model_frame(32'h8403ABCD, 20, n_wr, ew, n_rd, er, em);
    run_frame(32'h8403ABCD, 20, m, oa, oo);
    tests_run++;
    if (wr_log.size() != n_wr || rd_log.size() != n_rd) begin
      tests_failed++;
      $display("FAIL abort_no_strobe: wr=%0d rd=%0d required %0d %0d", wr_log.size(), rd_log.size(), n_wr, n_rd);
    end
    wr_log.delete(); rd_log.delete();
    model_frame(32'h84035678, 32, n_wr, ew, n_rd, er, em);
    run_frame(32'h84035678, 32, m, oa, oo);
    tests_run++;
    if (wr_log.size() != 1 || wr_log[0] !== ew) begin
      tests_failed++;
      $display("FAIL abort_next_frame: wr=%0d item=%h required 1 %h", wr_log.size(),
               (wr_log.size() > 0) ? wr_log[0] : 30'h0, ew);
    end
  endtask

  task automatic test_reserved();
    int n_wr, n_rd; logic [29:0] ew; logic [13:0] er; logic [31:0] em, m; logic oa, oo;
    wr_log.delete(); rd_log.delete();
    model_frame(32'hC4051111, 32, n_wr, ew, n_rd, er, em);
    run_frame(32'hC4051111, 32, m, oa, oo);
    tests_run++;
    if (wr_log.size() != 0 || rd_log.size() != 0 || m !== 32'h0) begin
      tests_failed++;
      $display("FAIL reserved_bit: wr=%0d rd=%0d miso=%h required 0 0 00000000", wr_log.size(), rd_log.size(), m);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n_wr, n_rd; logic [29:0] ew; logic [13:0] er; logic [31:0] em, m, w; logic b, oe, oo, oa;
    w = 32'h8406CAFE;
    m = '0; oo = 1'b0;
    wr_log.delete(); rd_log.delete();
    spi_cs_n = 1'b0;
    #HALF;
    for (int i = 0; i < 10; i++) spi_bit(w[31-i], b, oe);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int i = 10; i < 32; i++) begin
      spi_bit(w[31-i], b, oe);
      m[31-i] = b;
      oo |= oe;
    end
    #HALF;
    tests_run++;
    if (wr_log.size() != 0 || rd_log.size() != 0) begin
      tests_failed++;
      $display("FAIL rst_mid_strobes: wr=%0d rd=%0d required 0 0", wr_log.size(), rd_log.size());
    end
    tests_run++;
    if ({addr, write_data} !== 30'h0 || m !== 32'h0 || oo !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: addr=%h wdata=%h miso=%h oe=%b required 0 0 0 0", addr, write_data, m, oo);
    end
    spi_cs_n = 1'b1;
    #GAP;
    model_frame(32'h8407F00D, 32, n_wr, ew, n_rd, er, em);
    run_frame(32'h8407F00D, 32, m, oa, oo);
    tests_run++;
    if (wr_log.size() != 1 || wr_log[0] !== ew) begin
      tests_failed++;
      $display("FAIL rst_mid_recover: wr=%0d item=%h required 1 %h", wr_log.size(),
               (wr_log.size() > 0) ? wr_log[0] : 30'h0, ew);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] frames[4];
    logic [29:0] exp_wr[$];
    logic [13:0] exp_rd[$];
    int n_wr, n_rd; logic [29:0] ew; logic [13:0] er; logic [31:0] em, m; logic oa, oo;
    logic [13:0] a0, a1;
    a0 = 14'($urandom_range(16, 31));
    a1 = 14'($urandom_range(32, 47));
    frames[0] = {2'b10, a0, 16'($urandom)};
    frames[1] = {2'b00, a0, 16'h0};
    frames[2] = {2'b10, a1, 16'($urandom)};
    frames[3] = {2'b00, a1, 16'hFFFF};
    wr_log.delete(); rd_log.delete();
    for (int f = 0; f < 4; f++) begin
      model_frame(frames[f], 32, n_wr, ew, n_rd, er, em);
      if (n_wr == 1) exp_wr.push_back(ew);
      if (n_rd == 1) exp_rd.push_back(er);
      run_frame(frames[f], 32, m, oa, oo);
      tests_run++;
      if (m !== em) begin
        tests_failed++;
        $display("FAIL b2b_miso_%0d: got %h required %h", f, m, em);
      end
    end
    tests_run++;
    if (wr_log != exp_wr || rd_log != exp_rd) begin
      tests_failed++;
      $display("FAIL b2b_order: wr=%0d rd=%0d required %0d %0d (or contents differ)",
               wr_log.size(), rd_log.size(), exp_wr.size(), exp_rd.size());
    end
  endtask

  task automatic test_random();
    int n_wr, n_rd, nbits, op; logic [29:0] ew; logic [13:0] er; logic [31:0] em, m, w; logic oa, oo;
    for (int t = 0; t < 24; t++) begin
      op    = int'($urandom_range(0, 9));
      nbits = ($urandom_range(0, 3) == 0) ? 36 : 32;
      w[31] = (op < 5);
      w[30] = (op == 9);
      w[29:16] = 14'($urandom_range(0, 15)) | 14'h200;
      w[15:0]  = 16'($urandom);
      wr_log.delete(); rd_log.delete();
      model_frame(w, nbits, n_wr, ew, n_rd, er, em);
      run_frame(w, nbits, m, oa, oo);
      tests_run++;
      if (wr_log.size() != n_wr || rd_log.size() != n_rd ||
          (n_wr == 1 && wr_log[0] !== ew) || (n_rd == 1 && rd_log[0] !== er) || m !== em) begin
        tests_failed++;
        $display("FAIL rand_%0d frame=%h bits=%0d: wr=%0d rd=%0d miso=%h required %0d %0d %h",
                 t, w, nbits, wr_log.size(), rd_log.size(), m, n_wr, n_rd, em);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_reserved();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    tests_run++;
    if (overlap !== 0) begin
      tests_failed++;
      $display("FAIL strobe_overlap: cycles with wr_en and rd_en both high=%0d required 0", overlap);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
